// File: rtl/fetch_stall_stage.sv
// ============================================================================
// Module   : fetch_stall_stage
// Purpose  : Fetch-side PC register and IF/ID pipeline latch. Advances the
//            PC, holds it on a stall, or redirects it on a taken branch.
//            Latches, holds or flushes IF/ID. Counts stall and flush cycles,
//            and sets a sticky error flag when a stall runs too long.
// Ports    : Clk, Rst (async, active-high)
//            hazardPCWrite / hazardIFIDWrite : stall requests (1 = hold)
//            inBranchTaken / inBranchTarget  : redirect and flush
//            inInstruction                   : imem data for outPC
//            outPC, outIFIDInstruction, outIFIDPCPlus4, outIFIDValid
//            outState (00 RUN, 01 STALL, 10 FLUSH)
//            outStallCount, outFlushCount (saturating), outStallError
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stall_stage #(
  parameter int                PC_WIDTH    = 32,
  parameter int                INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                CNT_WIDTH   = 16,
  parameter int                MAX_STALL   = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   hazardPCWrite,
  input  logic                   hazardIFIDWrite,
  input  logic                   inBranchTaken,
  input  logic [PC_WIDTH-1:0]    inBranchTarget,
  input  logic [INSTR_WIDTH-1:0] inInstruction,
  output logic [PC_WIDTH-1:0]    outPC,
  output logic [INSTR_WIDTH-1:0] outIFIDInstruction,
  output logic [PC_WIDTH-1:0]    outIFIDPCPlus4,
  output logic                   outIFIDValid,
  output logic [1:0]             outState,
  output logic [CNT_WIDTH-1:0]   outStallCount,
  output logic [CNT_WIDTH-1:0]   outFlushCount,
  output logic                   outStallError
);

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_STALL = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;

  // Consecutive-stall counter only needs to reach MAX_STALL+1, then it parks.
  localparam int               CONS_W   = $clog2(MAX_STALL + 2);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(MAX_STALL + 1);
  localparam logic [CONS_W-1:0] CONS_LIM = CONS_W'(MAX_STALL);

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pp4_q, ifid_pp4_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CONS_W-1:0]      cons_q, cons_d;
  logic                   err_q, err_d;

  logic                   stall_cycle;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [PC_WIDTH-1:0]    target_aligned;

  // A branch overrides both hazard bits, so such a cycle is never a stall.
  assign stall_cycle    = (hazardPCWrite | hazardIFIDWrite) & ~inBranchTaken;
  assign pc_plus4       = pc_q + PC_WIDTH'(4);
  assign target_aligned = inBranchTarget & ~PC_WIDTH'(3);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = S_RUN;
    if (inBranchTaken)    state_d = S_FLUSH;
    else if (stall_cycle) state_d = S_STALL;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    outState = state_q;
  end

  // ---------------- Datapath next-state ----------------
  always_comb begin
    pc_d         = pc_plus4;
    ifid_instr_d = inInstruction;
    ifid_pp4_d   = pc_plus4;
    ifid_valid_d = 1'b1;
    if (inBranchTaken) begin
      pc_d         = target_aligned;
      ifid_instr_d = '0;
      ifid_pp4_d   = '0;
      ifid_valid_d = 1'b0;
    end else begin
      // The two hazard bits act independently on PC and IF/ID.
      if (hazardPCWrite) pc_d = pc_q;
      if (hazardIFIDWrite) begin
        ifid_instr_d = ifid_instr_q;
        ifid_pp4_d   = ifid_pp4_q;
        ifid_valid_d = ifid_valid_q;
      end
    end
  end

  // ---------------- Counters and watchdog ----------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    cons_d      = '0;
    err_d       = err_q;
    if (stall_cycle && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (inBranchTaken && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    if (stall_cycle) begin
      cons_d = (cons_q == CONS_MAX) ? cons_q : cons_q + CONS_W'(1);
      // This stall is number MAX_STALL+1 in a row.
      if (cons_q == CONS_LIM) err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pp4_q   <= '0;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      cons_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pp4_q   <= ifid_pp4_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      cons_q       <= cons_d;
      err_q        <= err_d;
    end
  end

  assign outPC              = pc_q;
  assign outIFIDInstruction = ifid_instr_q;
  assign outIFIDPCPlus4     = ifid_pp4_q;
  assign outIFIDValid       = ifid_valid_q;
  assign outStallCount      = stall_cnt_q;
  assign outFlushCount      = flush_cnt_q;
  assign outStallError      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stall_stage.sv
// ============================================================================
// Module   : tb_fetch_stall_stage
// Purpose  : Directed, table-driven bench for fetch_stall_stage, plus
//            hand-written sequences for async reset and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stall_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        hpc, hif, br;
  logic [31:0] tgt, instr;
  logic [31:0] pc, ins, pp4;
  logic        vld, err;
  logic [1:0]  st;
  logic [15:0] sc, fc;

  // Second instance with narrow counters for the saturation check.
  logic        s_hpc, s_hif;
  logic [31:0] s_pc, s_ins, s_pp4;
  logic        s_vld, s_err;
  logic [1:0]  s_st, s_sc, s_fc;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fetch_stall_stage dut (
    .Clk(Clk), .Rst(Rst),
    .hazardPCWrite(hpc), .hazardIFIDWrite(hif),
    .inBranchTaken(br), .inBranchTarget(tgt), .inInstruction(instr),
    .outPC(pc), .outIFIDInstruction(ins), .outIFIDPCPlus4(pp4),
    .outIFIDValid(vld), .outState(st),
    .outStallCount(sc), .outFlushCount(fc), .outStallError(err)
  );

  fetch_stall_stage #(.CNT_WIDTH(2)) dut2 (
    .Clk(Clk), .Rst(Rst),
    .hazardPCWrite(s_hpc), .hazardIFIDWrite(s_hif),
    .inBranchTaken(1'b0), .inBranchTarget(32'h0), .inInstruction(32'h1234_5678),
    .outPC(s_pc), .outIFIDInstruction(s_ins), .outIFIDPCPlus4(s_pp4),
    .outIFIDValid(s_vld), .outState(s_st),
    .outStallCount(s_sc), .outFlushCount(s_fc), .outStallError(s_err)
  );

  typedef struct {
    logic        hpc, hif, br;
    logic [31:0] tgt, instr;
    logic [31:0] pc, ins, pp4;
    logic        vld;
    logic [1:0]  st;
    logic [15:0] sc, fc;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    pc,           32'h0);
    chk({tag, "_ins"},   ins,          32'h0);
    chk({tag, "_pp4"},   pp4,          32'h0);
    chk({tag, "_vld"},   {31'h0, vld}, 32'h0);
    chk({tag, "_st"},    {30'h0, st},  32'h0);
    chk({tag, "_sc"},    {16'h0, sc},  32'h0);
    chk({tag, "_fc"},    {16'h0, fc},  32'h0);
    chk({tag, "_err"},   {31'h0, err}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; hpc = 0; hif = 0; br = 0; tgt = 0; instr = 0;
    s_hpc = 0; s_hif = 0;

    //           hpc hif br tgt           instr          pc            ins           pp4          vld st     sc  fc  err
    vq.push_back('{0, 0, 0, 32'h0,        32'h2008_0005, 32'h4,        32'h2008_0005, 32'h4,       1, 2'b00, 0, 0, 0});
    vq.push_back('{0, 0, 0, 32'h0,        32'h2008_0005, 32'h8,        32'h2008_0005, 32'h8,       1, 2'b00, 0, 0, 0});
    vq.push_back('{0, 0, 0, 32'h0,        32'h2008_0005, 32'hC,        32'h2008_0005, 32'hC,       1, 2'b00, 0, 0, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'hDEAD_BEEF, 32'hC,        32'h2008_0005, 32'hC,       1, 2'b01, 1, 0, 0});
    vq.push_back('{0, 0, 0, 32'h0,        32'h1111_1111, 32'h10,       32'h1111_1111, 32'h10,      1, 2'b00, 1, 0, 0});
    vq.push_back('{1, 1, 1, 32'h43,       32'h2222_2222, 32'h40,       32'h0,         32'h0,       0, 2'b10, 1, 1, 0});
    vq.push_back('{0, 0, 0, 32'h0,        32'h3333_3333, 32'h44,       32'h3333_3333, 32'h44,      1, 2'b00, 1, 1, 0});
    vq.push_back('{1, 0, 0, 32'h0,        32'h4444_4444, 32'h44,       32'h4444_4444, 32'h48,      1, 2'b01, 2, 1, 0});
    vq.push_back('{0, 1, 0, 32'h0,        32'h5555_5555, 32'h48,       32'h4444_4444, 32'h48,      1, 2'b01, 3, 1, 0});
    vq.push_back('{0, 0, 0, 32'h0,        32'h6666_6666, 32'h4C,       32'h6666_6666, 32'h4C,      1, 2'b00, 3, 1, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'h9999_9999, 32'h4C,       32'h6666_6666, 32'h4C,      1, 2'b01, 4, 1, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'h9999_9999, 32'h4C,       32'h6666_6666, 32'h4C,      1, 2'b01, 5, 1, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'h9999_9999, 32'h4C,       32'h6666_6666, 32'h4C,      1, 2'b01, 6, 1, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'h9999_9999, 32'h4C,       32'h6666_6666, 32'h4C,      1, 2'b01, 7, 1, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'h9999_9999, 32'h4C,       32'h6666_6666, 32'h4C,      1, 2'b01, 8, 1, 1});
    vq.push_back('{0, 0, 0, 32'h0,        32'h7777_7777, 32'h50,       32'h7777_7777, 32'h50,      1, 2'b00, 8, 1, 1});
    vq.push_back('{0, 0, 1, 32'hFFFF_FFFE, 32'hAAAA_AAAA, 32'hFFFF_FFFC, 32'h0,        32'h0,       0, 2'b10, 8, 2, 1});
    vq.push_back('{0, 0, 1, 32'hFFFF_FFFC, 32'hBBBB_BBBB, 32'hFFFF_FFFC, 32'h0,        32'h0,       0, 2'b10, 8, 3, 1});
    vq.push_back('{0, 0, 0, 32'h0,        32'h8888_8888, 32'h0,        32'h8888_8888, 32'h0,       1, 2'b00, 8, 3, 1});

    @(posedge Clk); @(posedge Clk); #1;
    chk_reset("rst_held");
    Rst = 1'b0;
    chk_reset("rst_rel");

    for (int i = 0; i < vq.size(); i++) begin
      hpc = vq[i].hpc; hif = vq[i].hif; br = vq[i].br;
      tgt = vq[i].tgt; instr = vq[i].instr;
      @(posedge Clk); #1;
      chk($sformatf("v%0d_pc", i),  pc,                vq[i].pc);
      chk($sformatf("v%0d_ins", i), ins,               vq[i].ins);
      chk($sformatf("v%0d_pp4", i), pp4,               vq[i].pp4);
      chk($sformatf("v%0d_vld", i), {31'h0, vld},      {31'h0, vq[i].vld});
      chk($sformatf("v%0d_st", i),  {30'h0, st},       {30'h0, vq[i].st});
      chk($sformatf("v%0d_sc", i),  {16'h0, sc},       {16'h0, vq[i].sc});
      chk($sformatf("v%0d_fc", i),  {16'h0, fc},       {16'h0, vq[i].fc});
      chk($sformatf("v%0d_err", i), {31'h0, err},      {31'h0, vq[i].err});
    end

    // Async reset in the middle of a stall, between edges.
    hpc = 1; hif = 1; br = 0; instr = 32'hCCCC_CCCC;
    @(posedge Clk); #1;
    chk("pre_rst_st", {30'h0, st}, 32'h1);
    #1 Rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(negedge Clk);
    Rst = 1'b0; hpc = 0; hif = 0; instr = 32'h2008_0005;
    @(posedge Clk); #1;
    chk("post_rst_pc",  pc,  32'h4);
    chk("post_rst_pp4", pp4, 32'h4);
    chk("post_rst_ins", ins, 32'h2008_0005);
    chk("post_rst_vld", {31'h0, vld}, 32'h1);

    // Saturation with a 2-bit stall counter (dut2 was reset above).
    s_hpc = 1; s_hif = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("sat%0d_sc", k), {30'h0, s_sc}, (k < 3) ? k : 3);
    end
    chk("sat_err", {31'h0, s_err}, 32'h1);
    s_hpc = 0; s_hif = 0;
    @(posedge Clk); #1;
    chk("sat_hold_sc", {30'h0, s_sc}, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
